// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - round-robin arbiter feeding one parallel-to-serial converter
module serial_tx_scheduler #(
    parameter int N       = 4,
    parameter int WORD_W  = 32,
    parameter int GAP_CYC = 2,
    parameter int IDW     = $clog2(N)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  EN,
    input  logic [N-1:0]          REQ,
    input  logic [N*WORD_W-1:0]   REQ_DATA,
    output logic [N-1:0]          GNT,
    output logic [WORD_W-1:0]     P_OUT,
    output logic                  S_START,
    output logic [IDW-1:0]        SRC_ID,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [WORD_W-1:0] p_out_q, p_out_d;
    logic              s_start_q, s_start_d;
    logic [IDW-1:0]    src_id_q, src_id_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] words [N];
    logic              found;
    logic [IDW-1:0]    sel;
    logic [IDW:0]      cand;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign words[g] = REQ_DATA[g*WORD_W +: WORD_W];
    end

    // Rotating priority scan starting at the pointer, wrapping mod N.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!found && REQ[cand[IDW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        gnt_d     = '0;
        p_out_d   = p_out_q;
        s_start_d = s_start_q;
        src_id_d  = src_id_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN && found) begin
                    gnt_d     = N'(1) << sel;
                    p_out_d   = words[sel];
                    src_id_d  = sel;
                    ptr_d     = (sel == IDW'(N-1)) ? '0 : sel + IDW'(1);
                    cnt_d     = '0;
                    s_start_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(WORD_W-1)) begin
                    s_start_d = 1'b0;
                    done_d    = 1'b1;
                    if (GAP_CYC > 0) begin
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC-1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            p_out_q   <= '0;
            s_start_q <= 1'b0;
            src_id_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            p_out_q   <= p_out_d;
            s_start_q <= s_start_d;
            src_id_q  <= src_id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign GNT     = gnt_q;
    assign P_OUT   = p_out_q;
    assign S_START = s_start_q;
    assign SRC_ID  = src_id_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb/tb_serial_tx_scheduler.sv - scoreboard bench for serial_tx_scheduler
module tb_serial_tx_scheduler;
    localparam int W = 32;

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic [31:0] data;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RESET, EN;
    logic [3:0]   REQ, REQ0;
    logic [127:0] REQ_DATA;
    logic [3:0]   GNT, GNT0;
    logic [31:0]  P_OUT, P_OUT0;
    logic         S_START, S_START0, BUSY, BUSY0, DONE, DONE0;
    logic [1:0]   SRC_ID, SRC_ID0;

    int errors = 0, checks = 0;
    int grants = 0, dones = 0, grants0 = 0, dones0 = 0;
    exp_t q[$], q0[$];
    exp_t e, e0;

    localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h2222_0001,
                            W2 = 32'hA5A5_0F0F, W3 = 32'hC3C3_3C3C;

    always #5 CLK = ~CLK;

    serial_tx_scheduler #(.N(4), .WORD_W(W), .GAP_CYC(2)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REQ(REQ), .REQ_DATA(REQ_DATA),
        .GNT(GNT), .P_OUT(P_OUT), .S_START(S_START), .SRC_ID(SRC_ID),
        .BUSY(BUSY), .DONE(DONE));

    serial_tx_scheduler #(.N(4), .WORD_W(W), .GAP_CYC(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .REQ(REQ0), .REQ_DATA(REQ_DATA),
        .GNT(GNT0), .P_OUT(P_OUT0), .S_START(S_START0), .SRC_ID(SRC_ID0),
        .BUSY(BUSY0), .DONE(DONE0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [3:0] g, input logic [1:0] id, input logic [31:0] d);
        exp_t x;
        x.gnt = g; x.id = id; x.data = d;
        if (which == 0) q.push_back(x);
        else q0.push_back(x);
    endtask

    task automatic wait_grants(input int which, input int k);
        int t = 0;
        while (((which == 0) ? grants : grants0) < k && t < 5000) begin
            @(posedge CLK); t++;
        end
        #1;
        chk("grant_timeout", 64'(((which == 0) ? grants : grants0) >= k), 64'd1);
    endtask

    task automatic wait_dones(input int which, input int k);
        int t = 0;
        while (((which == 0) ? dones : dones0) < k && t < 5000) begin
            @(posedge CLK); t++;
        end
        #1;
        chk("done_timeout", 64'(((which == 0) ? dones : dones0) >= k), 64'd1);
    endtask

    // Monitor for the GAP_CYC=2 instance.
    int run = 0, low = 0;
    logic s_prev = 1'b0, rst_prev = 1'b0, word_done = 1'b0;
    logic [31:0] held = '0;
    always @(negedge CLK) begin
        if (rst_prev) begin
            chk("reset_outputs", 64'({GNT, S_START, BUSY, DONE, P_OUT, SRC_ID}), 64'd0);
            run = 0; low = 0; word_done = 1'b0;
        end else begin
            if (GNT != 4'b0) begin
                grants++;
                if (q.size() == 0) chk("unexpected_grant", 64'(GNT), 64'd0);
                else begin
                    e = q.pop_front();
                    chk("grant", 64'(GNT), 64'(e.gnt));
                    chk("src_id", 64'(SRC_ID), 64'(e.id));
                    chk("p_out", 64'(P_OUT), 64'(e.data));
                    chk("grant_starts_shift", 64'(S_START), 64'd1);
                end
                held = P_OUT;
            end
            if (S_START) run++;
            if (s_prev && !S_START) begin
                chk("shift_len", 64'(run), 64'(W));
                chk("done_pulse", 64'(DONE), 64'd1);
                chk("p_out_hold", 64'(P_OUT), 64'(held));
                dones++;
                run = 0; low = 0; word_done = 1'b1;
            end else if (DONE) begin
                chk("spurious_done", 64'(DONE), 64'd0);
            end
            if (!S_START && word_done) begin
                low++;
                if (low == 2) chk("busy_in_gap", 64'(BUSY), 64'd1);
                if (low == 3) begin
                    chk("busy_after_gap", 64'(BUSY), 64'd0);
                    word_done = 1'b0;
                end
            end
        end
        s_prev = S_START;
        rst_prev = RESET;
    end

    // Monitor for the GAP_CYC=0 instance.
    int run0 = 0, low0 = 0;
    logic s0_prev = 1'b0, rst0_prev = 1'b0, wd0 = 1'b0;
    always @(negedge CLK) begin
        if (rst0_prev) begin
            run0 = 0; low0 = 0; wd0 = 1'b0;
        end else begin
            if (GNT0 != 4'b0) begin
                grants0++;
                if (q0.size() == 0) chk("unexpected_grant0", 64'(GNT0), 64'd0);
                else begin
                    e0 = q0.pop_front();
                    chk("grant0", 64'(GNT0), 64'(e0.gnt));
                    chk("src_id0", 64'(SRC_ID0), 64'(e0.id));
                    chk("p_out0", 64'(P_OUT0), 64'(e0.data));
                end
            end
            if (S_START0 && !s0_prev && wd0) begin
                chk("b2b_low_cycles", 64'(low0), 64'd1);
                wd0 = 1'b0;
            end
            if (S_START0) run0++;
            if (s0_prev && !S_START0) begin
                chk("shift_len0", 64'(run0), 64'(W));
                chk("done0", 64'(DONE0), 64'd1);
                dones0++;
                run0 = 0; low0 = 0; wd0 = 1'b1;
            end else if (DONE0) begin
                chk("spurious_done0", 64'(DONE0), 64'd0);
            end
            if (!S_START0 && wd0) low0++;
        end
        s0_prev = S_START0;
        rst0_prev = RESET;
    end

    initial begin
        RESET = 1'b1; EN = 1'b1; REQ = 4'b1111; REQ0 = 4'b0000;
        REQ_DATA = {W3, W2, W1, W0};
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", 64'({GNT, S_START, BUSY, DONE, P_OUT}), 64'd0);

        // Round-robin with all requesters held, starting at 0 after reset
        push(0, 4'b0001, 2'd0, W0);
        push(0, 4'b0010, 2'd1, W1);
        push(0, 4'b0100, 2'd2, W2);
        push(0, 4'b1000, 2'd3, W3);
        push(0, 4'b0001, 2'd0, W0);
        RESET = 1'b0;
        wait_grants(0, 5);
        REQ = 4'b0000;
        wait_dones(0, 5);
        repeat (4) @(posedge CLK);
        #1;
        chk("idle_busy", 64'(BUSY), 64'd0);

        // Single word from requester 2
        push(0, 4'b0100, 2'd2, W2);
        REQ = 4'b0100;
        wait_grants(0, 6);
        REQ = 4'b0000;
        wait_dones(0, 6);
        repeat (4) @(posedge CLK);
        #1;

        // EN gating
        EN = 1'b0; REQ = 4'b1000;
        repeat (10) @(posedge CLK);
        #1;
        chk("en0_no_grant", 64'(grants), 64'd6);
        push(0, 4'b1000, 2'd3, W3);
        EN = 1'b1;
        @(posedge CLK);
        #1;
        chk("en1_grant_latency", 64'(GNT), 64'b1000);
        REQ = 4'b0000;
        repeat (5) @(posedge CLK);
        #1;
        EN = 1'b0;
        wait_dones(0, 7);
        repeat (4) @(posedge CLK);
        #1;
        EN = 1'b1;

        // Reset during shift cycle 10
        push(0, 4'b0001, 2'd0, W0);
        REQ = 4'b0001;
        @(posedge CLK);
        #1;
        chk("rst_word_grant", 64'(GNT), 64'b0001);
        REQ = 4'b0000;
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("midword_reset", 64'({S_START, DONE, BUSY, P_OUT}), 64'd0);
        RESET = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        chk("no_done_after_reset", 64'(dones), 64'd7);
        push(0, 4'b1000, 2'd3, W3);
        REQ = 4'b1000;
        @(posedge CLK);
        #1;
        chk("first_grant_after_reset", 64'(GNT), 64'b1000);
        REQ = 4'b0000;
        wait_dones(0, 8);

        // Back-to-back words with no gap
        push(1, 4'b0001, 2'd0, W0);
        push(1, 4'b0010, 2'd1, W1);
        REQ0 = 4'b0011;
        wait_grants(1, 2);
        REQ0 = 4'b0000;
        wait_dones(1, 2);
        repeat (4) @(posedge CLK);
        #1;

        chk("scoreboard_drained", 64'(q.size() + q0.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
